// File: rtl/serial_thermometer_sequencer_if.sv
// Handshake bundle for the serial thermometer sequencer: word input side,
// serial bit output side, abort and status.
interface serial_thermometer_sequencer_if #(
   parameter int INPUT_WIDTH = 3
);
   logic                   in_valid;
   logic                   in_ready;
   logic [INPUT_WIDTH:0]   binary_in;
   logic                   abort;
   logic                   out_ready;
   logic                   therm_valid;
   logic                   therm_bit;
   logic                   therm_first;
   logic                   therm_last;
   logic                   busy;
   logic                   done;
   logic                   sat_flag;

   modport master (
      output in_valid, binary_in, abort, out_ready,
      input  in_ready, therm_valid, therm_bit, therm_first, therm_last,
             busy, done, sat_flag
   );

   modport slave (
      input  in_valid, binary_in, abort, out_ready,
      output in_ready, therm_valid, therm_bit, therm_first, therm_last,
             busy, done, sat_flag
   );
endinterface

// File: rtl/serial_thermometer_sequencer.sv
// Converts one binary magnitude per transaction into a serial thermometer code,
// MSB first (ones then zeros), with downstream backpressure and synchronous abort.
module serial_thermometer_sequencer #(
   parameter int INPUT_WIDTH = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   serial_thermometer_sequencer_if.slave bus
);

   localparam int THERMO_LEN = (1 << INPUT_WIDTH) - 1;
   localparam logic [INPUT_WIDTH:0]   LEN_W    = (INPUT_WIDTH+1)'(THERMO_LEN);
   localparam logic [INPUT_WIDTH-1:0] LAST_CNT = INPUT_WIDTH'(THERMO_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [INPUT_WIDTH-1:0] cnt_q, cnt_d;
   logic [INPUT_WIDTH:0]   val_q, val_d;
   logic                   sat_q, sat_d;
   logic                   armed_q, armed_d;

   logic in_ready_c, therm_valid_c, therm_bit_c, therm_first_c, therm_last_c;
   logic busy_c, done_c;

   function automatic logic [INPUT_WIDTH:0] clamp_mag(input logic [INPUT_WIDTH:0] x);
      return (x > LEN_W) ? LEN_W : x;
   endfunction

   function automatic logic over_range(input logic [INPUT_WIDTH:0] x);
      return (x > LEN_W);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         val_q   <= '0;
         sat_q   <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         val_q   <= val_d;
         sat_q   <= sat_d;
         armed_q <= armed_d;
      end
   end

   // armed_q keeps in_ready low until the first clock edge after reset release.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      val_d         = val_q;
      sat_d         = sat_q;
      armed_d       = 1'b1;
      in_ready_c    = 1'b0;
      therm_valid_c = 1'b0;
      therm_bit_c   = 1'b0;
      therm_first_c = 1'b0;
      therm_last_c  = 1'b0;
      busy_c        = 1'b0;
      done_c        = 1'b0;

      case (state_q)
         S_IDLE: begin
            in_ready_c = armed_q;
            if (bus.in_valid && armed_q) begin
               val_d   = clamp_mag(bus.binary_in);
               sat_d   = over_range(bus.binary_in);
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            busy_c        = 1'b1;
            therm_valid_c = 1'b1;
            therm_bit_c   = ({1'b0, cnt_q} < val_q);
            therm_first_c = (cnt_q == '0);
            therm_last_c  = (cnt_q == LAST_CNT);
            if (bus.out_ready) begin
               if (cnt_q == LAST_CNT) state_d = S_DONE;
               else                   cnt_d   = cnt_q + INPUT_WIDTH'(1);
            end
         end
         S_DONE: begin
            busy_c  = 1'b1;
            done_c  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort overrides accept, transfer and the DONE exit.
      if (bus.abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         sat_d   = 1'b0;
      end
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.therm_valid = therm_valid_c;
   assign bus.therm_bit   = therm_bit_c;
   assign bus.therm_first = therm_first_c;
   assign bus.therm_last  = therm_last_c;
   assign bus.busy        = busy_c;
   assign bus.done        = done_c;
   assign bus.sat_flag    = sat_q;

endmodule

// File: tb/tb_serial_thermometer_sequencer.sv
// Directed plus randomized bench for serial_thermometer_sequencer against a
// queue-based reference model of the serial thermometer stream.
module tb_serial_thermometer_sequencer;

   localparam int W = 3;
   localparam int L = 7;

   logic clk = 1'b0;
   logic rst;

   serial_thermometer_sequencer_if #(.INPUT_WIDTH(W)) bus ();

   serial_thermometer_sequencer #(.INPUT_WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: queue of bits still to be sent for the current word.
   bit   m_q[$];
   int   m_pos;
   bit   m_done;
   bit   m_sat;
   bit   m_armed;
   logic [L-1:0] exp_word;
   logic [L-1:0] act_word;

   task automatic chk1(input string tag, input logic obs, input logic expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic chkw(input string tag, input logic [L-1:0] obs, input logic [L-1:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pos   = 0;
      m_done  = 1'b0;
      m_sat   = 1'b0;
      m_armed = 1'b0;
   endtask

   function automatic bit model_idle();
      return (m_q.size() == 0) && !m_done && m_armed;
   endfunction

   // One cycle: check outputs (at negedge), drive inputs, advance model, wait a clock.
   task automatic step(input logic r, input logic iv, input logic [W:0] b,
                       input logic ab, input logic ordy);
      bit streaming;
      int m;
      streaming = (m_q.size() != 0);

      chk1("in_ready",    bus.in_ready,    m_armed && !streaming && !m_done);
      chk1("therm_valid", bus.therm_valid, streaming);
      chk1("busy",        bus.busy,        streaming || m_done);
      chk1("done",        bus.done,        m_done);
      chk1("sat_flag",    bus.sat_flag,    m_sat);
      if (streaming) begin
         chk1("therm_bit",   bus.therm_bit,   m_q[0]);
         chk1("therm_first", bus.therm_first, m_pos == 0);
         chk1("therm_last",  bus.therm_last,  m_q.size() == 1);
      end
      if (m_done) chkw("word", act_word, exp_word);

      if (streaming && ordy && !ab && !r)
         act_word = {act_word[L-2:0], bus.therm_bit};

      rst           = r;
      bus.in_valid  = iv;
      bus.binary_in = b;
      bus.abort     = ab;
      bus.out_ready = ordy;

      if (r) begin
         model_reset();
      end else begin
         if (ab) begin
            m_q.delete();
            m_pos  = 0;
            m_done = 1'b0;
            m_sat  = 1'b0;
         end else if (m_done) begin
            m_done = 1'b0;
         end else if (streaming) begin
            if (ordy) begin
               void'(m_q.pop_front());
               m_pos++;
               if (m_q.size() == 0) m_done = 1'b1;
            end
         end else if (m_armed && iv) begin
            m = (int'(b) > L) ? L : int'(b);
            for (int i = 0; i < L; i++) m_q.push_back(i < m);
            m_pos    = 0;
            m_sat    = (int'(b) > L);
            exp_word = ~({L{1'b1}} >> m);
            act_word = '0;
         end
         m_armed = 1'b1;
      end

      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic pick_ordy(input int mode, input int k);
      case (mode)
         0:       return 1'b1;
         1:       return (k % 3) == 0;
         default: return 1'($urandom % 2);
      endcase
   endfunction

   // Send one word, stream it out with the chosen backpressure, optionally abort.
   task automatic run_word(input logic [W:0] v, input int mode, input int abort_at,
                           input bit noisy);
      int k;
      k = 0;
      while (!model_idle() && k < 200) begin
         step(1'b0, 1'b0, '0, 1'b0, 1'b1);
         k++;
      end
      step(1'b0, 1'b1, v, 1'b0, pick_ordy(mode, 0));
      k = 0;
      while ((m_q.size() != 0 || m_done) && k < 200) begin
         if (noisy)
            step(1'b0, 1'($urandom % 2), (W+1)'($urandom), k == abort_at, pick_ordy(mode, k));
         else
            step(1'b0, 1'b0, '0, k == abort_at, pick_ordy(mode, k));
         k++;
      end
      chk1("word_timeout", k < 200, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      model_reset();
      exp_word      = '0;
      act_word      = '0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.binary_in = '0;
      bus.abort     = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);

      // Reset state and in_ready one clock after release
      chk1("rst_bit",   bus.therm_bit,   1'b0);
      chk1("rst_first", bus.therm_first, 1'b0);
      chk1("rst_last",  bus.therm_last,  1'b0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 4'd5, 1'b0, 1'b1);
      step(1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Plain word, all-zero and all-one words, saturation then clear
      run_word(4'd5, 0, -1, 1'b0);
      run_word(4'd0, 0, -1, 1'b0);
      run_word(4'd7, 0, -1, 1'b0);
      run_word(4'd12, 0, -1, 1'b0);
      run_word(4'd3, 0, -1, 1'b0);

      // Stalled stream, abort on third bit, recovery word
      run_word(4'd4, 1, -1, 1'b0);
      run_word(4'd6, 0, 2, 1'b0);
      run_word(4'd2, 0, -1, 1'b0);

      // Abort with in_valid in idle must not accept
      step(1'b0, 1'b1, 4'd9, 1'b1, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Asynchronous reset mid-word, off the clock edge
      step(1'b0, 1'b1, 4'd6, 1'b0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      #2;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      #1;
      chk1("arst_valid", bus.therm_valid, 1'b0);
      chk1("arst_bit",   bus.therm_bit,   1'b0);
      chk1("arst_ready", bus.in_ready,    1'b0);
      chk1("arst_busy",  bus.busy,        1'b0);
      chk1("arst_done",  bus.done,        1'b0);
      chk1("arst_sat",   bus.sat_flag,    1'b0);
      model_reset();
      @(negedge clk);
      step(1'b1, 1'b0, '0, 1'b0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      run_word(4'd1, 0, -1, 1'b0);

      // Randomized words, backpressure, stray in_valid and occasional abort
      for (int n = 0; n < 40; n++) begin
         run_word((W+1)'($urandom % 16), 2,
                  (($urandom % 6) == 0) ? int'($urandom % 10) : -1, 1'b1);
      end
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
